// File: rtl/slave_port_v3_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_port_v3_if : serial bus handshake bundle for slave_port_v3   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface slave_port_v3_if;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic master_ready;
  logic rd_bus;
  logic slave_ready;
  logic slave_valid;
  logic slave_err;
  logic busy;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  rd_bus, slave_ready, slave_valid, slave_err, busy
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output rd_bus, slave_ready, slave_valid, slave_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/slave_port_v3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_port_v3 : memory-backed bit-serial bus slave with bursts     |
// | Optional word parity: define SLAVE_PORT_PARITY_EN. Rev 1.0         |
// +--------------------------------------------------------------------+
module slave_port_v3 #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int BURST_WIDTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  slave_port_v3_if.slave bus
);

  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
`ifdef SLAVE_PORT_PARITY_EN
  localparam int WORD_BITS = DATA_WIDTH + 1;
`else
  localparam int WORD_BITS = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(ADDR_WIDTH + DATA_WIDTH + BURST_WIDTH + 2);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(BURST_WIDTH - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WRITE, S_RFETCH, S_RDATA, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [BURST_WIDTH-1:0]    len_q, len_d;
  logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     addr_next;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  assign addr_next = {addr_q[ADDR_WIDTH-2:0], bus.wr_bus};
  assign bus.busy  = (state_q != S_IDLE);

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    addr_d          = addr_q;
    len_d           = len_q;
    ptr_d           = ptr_q;
    shift_d         = shift_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    mem_we          = 1'b0;
    bus.slave_ready = 1'b0;
    bus.slave_valid = 1'b0;
    bus.rd_bus      = 1'b0;
    bus.slave_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.master_valid) begin
          mode_d  = bus.mode;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        bus.slave_ready = 1'b1;
        if (bus.master_valid) begin
          addr_d = addr_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            ptr_d   = addr_next[MEM_ADDR_WIDTH-1:0];
            err_d   = ((addr_next >> MEM_ADDR_WIDTH) != '0);
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        bus.slave_ready = 1'b1;
        if (bus.master_valid) begin
          len_d = {len_q[BURST_WIDTH-2:0], bus.wr_bus};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LEN_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? S_WDATA : S_RFETCH;
          end
        end
      end
      S_WDATA: begin
        bus.slave_ready = 1'b1;
        if (bus.master_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < DATA_BITS)
            shift_d = {shift_q[DATA_WIDTH-2:0], bus.wr_bus};
`ifdef SLAVE_PORT_PARITY_EN
          else if ((^shift_q) != bus.wr_bus)
            err_d = 1'b1;
`endif
          if (cnt_q == WORD_LAST) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we = ~err_q;
        ptr_d  = ptr_q + 1'b1;
        if (len_q == '0) begin
          state_d = S_DONE;
        end else begin
          len_d   = len_q - 1'b1;
          state_d = S_WDATA;
        end
      end
      S_RFETCH: begin
        shift_d = err_q ? '0 : mem[ptr_q];
        cnt_d   = '0;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        bus.slave_valid = 1'b1;
        bus.rd_bus      = shift_q[DATA_WIDTH-1];
`ifdef SLAVE_PORT_PARITY_EN
        // Rotating (not shifting) restores the full word for the parity bit.
        if (cnt_q == DATA_BITS)
          bus.rd_bus = ^shift_q;
`endif
        if (bus.master_ready) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], shift_q[DATA_WIDTH-1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == WORD_LAST) begin
            cnt_d = '0;
            ptr_d = ptr_q + 1'b1;
            if (len_q == '0) begin
              state_d = S_DONE;
            end else begin
              len_d   = len_q - 1'b1;
              state_d = S_RFETCH;
            end
          end
        end
      end
      S_DONE: begin
        bus.slave_err = err_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; a reset landing on a WRITE cycle drops the word.
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[ptr_q] <= shift_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_slave_port_v3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_slave_port_v3 : directed bench with frame-level memory model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_slave_port_v3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MW = 6;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slave_port_v3_if bus ();

  slave_port_v3 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MW), .BURST_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] ref_mem [64];
  logic       exp_bits [$];
  logic [7:0] rx_words [$];
  logic [7:0] rx_sr;
  int         rx_n;
  int         rx_bits;
  int         err_cnt;
  bit         chk_en = 1'b0;
  logic [7:0] wdata [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Compare process: every cycle, idle outputs quiet and read bits follow the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!bus.busy)
        check("idle_outputs", {bus.rd_bus, bus.slave_ready, bus.slave_valid, bus.slave_err}, 4'b0);
      if (bus.slave_err)
        err_cnt++;
      if (bus.slave_valid) begin
        check("rd_bit_pending", exp_bits.size() != 0, 1);
        if (exp_bits.size() != 0) begin
          check("rd_bus", bus.rd_bus, exp_bits[0]);
          if (bus.master_ready) begin
            exp_bits.delete(0);
            rx_sr = {rx_sr[6:0], bus.rd_bus};
            rx_n++;
            rx_bits++;
            if (rx_n == 8) begin
              rx_words.push_back(rx_sr);
              rx_n = 0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    bus.wr_bus       = b;
    bus.master_valid = 1'b1;
    @(negedge clk);
    while (!bus.slave_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("slave_ready_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic send_field(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic start_frame(input logic m, input logic [15:0] addr, input logic [3:0] len);
    err_cnt          = 0;
    bus.mode         = m;
    bus.master_valid = 1'b1;
    bus.wr_bus       = 1'b1;
    tick();
    bus.mode = ~m;
    send_field({16'h0, addr}, AW);
    send_field({28'h0, len}, BW);
  endtask

  task automatic finish_frame(input int exp_err);
    int n = 0;
    bus.master_valid = 1'b0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeout("busy_drop");
    check("slave_err_pulses", err_cnt, exp_err);
  endtask

  task automatic write_frame(input logic [15:0] addr, input int len, input int stall_at);
    int  k = 0;
    bit  bad;
    bad = (addr >> MW) != 0;
    start_frame(1'b1, addr, len[3:0]);
    for (int i = 0; i <= len; i++) begin
      for (int b = 7; b >= 0; b--) begin
        send_bit(wdata[i][b]);
        k++;
        if (k == stall_at) begin
          bus.master_valid = 1'b0;
          bus.wr_bus       = ~bus.wr_bus;
          repeat (3) tick();
        end
      end
    end
    finish_frame(bad ? 1 : 0);
    if (!bad)
      for (int i = 0; i <= len; i++) ref_mem[(int'(addr) + i) % 64] = wdata[i];
  endtask

  task automatic read_frame(input logic [15:0] addr, input int len, input int stall_at,
                            input bit chk_lat);
    bit         bad;
    int         base;
    int         n = 0;
    logic [7:0] w;
    bad = (addr >> MW) != 0;
    rx_words.delete();
    rx_n = 0;
    for (int i = 0; i <= len; i++) begin
      w = bad ? 8'h00 : ref_mem[(int'(addr) + i) % 64];
      for (int b = 7; b >= 0; b--) exp_bits.push_back(w[b]);
    end
    base             = rx_bits;
    bus.master_ready = 1'b1;
    start_frame(1'b0, addr, len[3:0]);
    bus.master_valid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      check("rfetch_no_valid", bus.slave_valid, 0);
      @(negedge clk);
      check("first_valid_2cyc", bus.slave_valid, 1);
    end
    if (stall_at > 0) begin
      while (rx_bits < base + stall_at && n < 300) begin
        @(posedge clk);
        n++;
      end
      if (n >= 300) timeout("stall_point");
      #1 bus.master_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("stall_valid_held", bus.slave_valid, 1);
      end
      @(posedge clk);
      #1 bus.master_ready = 1'b1;
    end
    finish_frame(bad ? 1 : 0);
    check("bits_delivered", exp_bits.size(), 0);
    check("words_received", rx_words.size(), len + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode         = 1'b0;
    bus.wr_bus       = 1'b0;
    bus.master_valid = 1'b0;
    bus.master_ready = 1'b0;
    rst              = 1'b1;
    rx_bits          = 0;
    rx_n             = 0;
    rx_sr            = '0;
    err_cnt          = 0;
    repeat (3) tick();
    check("reset_outputs",
          {bus.rd_bus, bus.slave_ready, bus.slave_valid, bus.slave_err, bus.busy}, 5'b0);
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single-word write then read back
    wdata[0] = 8'hA5;
    write_frame(16'h0005, 0, 0);
    read_frame(16'h0005, 0, 0, 1'b0);
    check("rd_0005", rx_words[0], 8'hA5);

    // Burst across the top of memory, wrapping to index 0
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
    write_frame(16'h003E, 3, 0);
    read_frame(16'h003E, 3, 0, 1'b1);
    check("burst_w0", rx_words[0], 8'h11);
    check("burst_w1", rx_words[1], 8'h22);
    check("burst_w2", rx_words[2], 8'h33);
    check("burst_w3", rx_words[3], 8'h44);
    read_frame(16'h0000, 1, 0, 1'b0);
    check("wrap_00", rx_words[0], 8'h33);
    check("wrap_01", rx_words[1], 8'h44);

    // Stalls on both directions
    wdata[0] = 8'h5A; wdata[1] = 8'hC3;
    write_frame(16'h0010, 1, 3);
    read_frame(16'h0010, 1, 2, 1'b0);
    check("stall_w0", rx_words[0], 8'h5A);
    check("stall_w1", rx_words[1], 8'hC3);

    // Out-of-range address: write suppressed, read returns zero, error pulse
    wdata[0] = 8'hFF;
    write_frame(16'h0100, 0, 0);
    read_frame(16'h0000, 0, 0, 1'b0);
    check("err_wr_suppressed", rx_words[0], 8'h33);
    read_frame(16'h0005, 0, 0, 1'b0);
    check("err_wr_a5_kept", rx_words[0], 8'hA5);
    read_frame(16'h0100, 0, 0, 1'b0);
    check("err_rd_zero", rx_words[0], 8'h00);

    // Reset in the middle of the address field
    err_cnt          = 0;
    bus.mode         = 1'b1;
    bus.master_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    bus.master_valid = 1'b0;
    rst              = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs",
          {bus.rd_bus, bus.slave_ready, bus.slave_valid, bus.slave_err, bus.busy}, 5'b0);
    check("midrst_no_err", err_cnt, 0);
    tick();
    wdata[0] = 8'h3C;
    write_frame(16'h0007, 0, 0);
    read_frame(16'h0007, 0, 0, 1'b1);
    check("post_rst_0007", rx_words[0], 8'h3C);
    read_frame(16'h003E, 0, 0, 1'b0);
    check("post_rst_003e", rx_words[0], 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
